logic_op_scheduler: RTL and testbench

Shares one parameterized bitwise logic unit (AND/OR/NOT/XOR/XNOR/NAND/NOR) among NUM_REQ requesters. A round-robin arbiter grants one request at a time. The block captures that request's opcode and operands, computes the result in a registered stage, and returns it on a valid/ready result port tagged with the requester index. It sits between the requesting datapath blocks and the shared logic resource.

---
 rtl/logic_op_pkg.sv | 20 ++
 rtl/logic_op_scheduler_rr_arbiter.sv | 34 +++
 rtl/logic_op_scheduler.sv | 122 ++++++++++++
 tb/tb_logic_op_scheduler.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// Shared opcode and FSM encodings for the logic-op scheduler.
// Imported by the scheduler top and its arbiter.
package logic_op_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_XNOR = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/logic_op_scheduler_rr_arbiter.sv
// Round-robin priority search starting at ptr, wrapping at NUM_REQ-1.
// Grant is one-hot and gated by en; idx is the winner when any req is set.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    import logic_op_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic found;
    int   k;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[k]) begin
                found    = 1'b1;
                idx      = ID_W'(k);
                grant[k] = en;
            end
        end
    end

endmodule

// File: rtl/logic_op_scheduler.sv
// Shares one bitwise logic unit among NUM_REQ requesters via round-robin.
// One op in flight: IDLE grants, EXEC computes, DONE holds the result.
module logic_op_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    input  logic [3*NUM_REQ-1:0]          req_op_in,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_a_in,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_b_in,
    output logic                          res_valid_out,
    input  logic                          res_ready_in,
    output logic [DATA_WIDTH-1:0]         res_data_out,
    output logic [ID_W-1:0]               res_id_out,
    output logic                          res_err_out
);
    import logic_op_pkg::*;

    state_t                state;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       gnt_idx;
    logic [ID_W-1:0]       ptr_nxt;
    logic [NUM_REQ-1:0]    gnt;
    logic                  arb_en;
    logic                  any_gnt;
    logic [2:0]            sel_op;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [2:0]            lat_op;
    logic [DATA_WIDTH-1:0] lat_a;
    logic [DATA_WIDTH-1:0] lat_b;
    logic [ID_W-1:0]       lat_id;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_err;

    // Grants only in IDLE and never while reset is held.
    assign arb_en = (state == IDLE) & rst_n_in;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (req_valid_in),
        .ptr   (rr_ptr),
        .en    (arb_en),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    assign req_ready_out = gnt;
    assign any_gnt       = |gnt;

    always_comb begin
        sel_op = req_op_in[3*int'(gnt_idx) +: 3];
        sel_a  = req_a_in[DATA_WIDTH*int'(gnt_idx) +: DATA_WIDTH];
        sel_b  = req_b_in[DATA_WIDTH*int'(gnt_idx) +: DATA_WIDTH];
    end

    assign ptr_nxt = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0
                                                   : gnt_idx + ID_W'(1);

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (lat_op)
            OP_AND:  alu_res = lat_a & lat_b;
            OP_OR:   alu_res = lat_a | lat_b;
            OP_NOT:  alu_res = ~lat_a;
            OP_XOR:  alu_res = lat_a ^ lat_b;
            OP_XNOR: alu_res = ~(lat_a ^ lat_b);
            OP_NAND: alu_res = ~(lat_a & lat_b);
            OP_NOR:  alu_res = ~(lat_a | lat_b);
            OP_RSVD: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            lat_op        <= '0;
            lat_a         <= '0;
            lat_b         <= '0;
            lat_id        <= '0;
            res_valid_out <= 1'b0;
            res_data_out  <= '0;
            res_id_out    <= '0;
            res_err_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_gnt) begin
                        lat_op <= sel_op;
                        lat_a  <= sel_a;
                        lat_b  <= sel_b;
                        lat_id <= gnt_idx;
                        rr_ptr <= ptr_nxt;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    res_data_out  <= alu_res;
                    res_id_out    <= lat_id;
                    res_err_out   <= alu_err;
                    res_valid_out <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (res_valid_out && res_ready_in) begin
                        res_valid_out <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Scoreboard bench for logic_op_scheduler: expectations queued at issue,
// popped and compared when a result is presented.
module tb_logic_op_scheduler;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [3*NR-1:0] req_op = '0;
    logic [DW*NR-1:0] req_a = '0;
    logic [DW*NR-1:0] req_b = '0;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [DW-1:0]   res_data;
    logic [IW-1:0]   res_id;
    logic            res_err;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic_op_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .ID_W       (IW)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .req_valid_in  (req_valid),
        .req_ready_out (req_ready),
        .req_op_in     (req_op),
        .req_a_in      (req_a),
        .req_b_in      (req_b),
        .res_valid_out (res_valid),
        .res_ready_in  (res_ready),
        .res_data_out  (res_data),
        .res_id_out    (res_id),
        .res_err_out   (res_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int i, input logic [2:0] op,
                                   input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.id   = IW'(i);
        e.err  = 1'b0;
        e.data = 8'h00;
        case (op)
            3'd0: e.data = a & b;
            3'd1: e.data = a | b;
            3'd2: e.data = ~a;
            3'd3: e.data = a ^ b;
            3'd4: e.data = ~(a ^ b);
            3'd5: e.data = ~(a & b);
            3'd6: e.data = ~(a | b);
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic set_req(input int i, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        req_op[3*i +: 3]  = op;
        req_a[DW*i +: DW] = a;
        req_b[DW*i +: DW] = b;
        req_valid[i]      = 1'b1;
    endtask

    // Raise a request at a negedge and hold it until granted;
    // returns at the negedge of the EXEC cycle with valid dropped.
    task automatic issue(input int i, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        bit got = 0;
        set_req(i, op, a, b);
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if (req_ready[i]) got = 1;
            else @(negedge clk);
        end
        if (got) begin
            @(negedge clk);
            req_valid[i] = 1'b0;
        end else begin
            checks++;
            errors++;
            $display("FAIL grant_timeout req=%0d ready=%b", i, req_ready);
            req_valid[i] = 1'b0;
            void'(exp_q.pop_back());
        end
    endtask

    task automatic wait_res(output bit ok);
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            if (res_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL result_timeout");
        end
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        set_req(0, 3'd1, 8'h12, 8'h34);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rst_ready got=%b exp=0000", req_ready);
        end
        checks++;
        if (res_valid !== 1'b0 || res_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid_err got=%b%b exp=00", res_valid, res_err);
        end
        checks++;
        if (res_data !== 8'h00 || res_id !== 2'd0) begin
            errors++;
            $display("FAIL rst_data_id got=%h/%0d exp=00/0", res_data, res_id);
        end
        req_valid = '0;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle got=%b/%b exp=0000/0", req_ready, res_valid);
            end
        end
    endtask

    task automatic test_single();
        exp_t e;
        set_req(2, 3'd3, 8'hF0, 8'h3C);
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant got=%b exp=0100", req_ready);
        end
        exp_q.push_back('{id: 2'd2, data: 8'hCC, err: 1'b0});
        @(negedge clk);
        req_valid[2] = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL single_exec got=%b/%b exp=0/0000", res_valid, req_ready);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency got=%b exp=1", res_valid);
        end
        e = exp_q.pop_front();
        checks++;
        if ({res_id, res_data, res_err} !== {e.id, e.data, e.err}) begin
            errors++;
            $display("FAIL single_res got=%0d/%h/%b exp=%0d/%h/%b",
                     res_id, res_data, res_err, e.id, e.data, e.err);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_clear got=%b exp=0", res_valid);
        end
    endtask

    task automatic test_opcodes();
        logic [7:0] tbl [0:7];
        exp_t e;
        bit   ok;
        tbl = '{8'h05, 8'hAF, 8'h5A, 8'hAA, 8'h55, 8'hFA, 8'h50, 8'h00};
        for (int op = 0; op < 8; op++) begin
            exp_q.push_back('{id: 2'd3, data: tbl[op], err: (op == 7)});
            issue(3, 3'(op), 8'hA5, 8'h0F);
            wait_res(ok);
            if (ok) begin
                e = exp_q.pop_front();
                checks++;
                if ({res_id, res_data, res_err} !== {e.id, e.data, e.err}) begin
                    errors++;
                    $display("FAIL op%0d got=%0d/%h/%b exp=%0d/%h/%b", op,
                             res_id, res_data, res_err, e.id, e.data, e.err);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fairness();
        logic [2:0] ops [0:3];
        int   exp_grant = 0;
        int   got_res = 0;
        exp_t e;
        ops = '{3'd0, 3'd1, 3'd3, 3'd5};
        for (int i = 0; i < NR; i++) set_req(i, ops[i], 8'h11 * 8'(i + 1), 8'h3C);
        for (int n = 0; n < 100 && got_res < 6; n++) begin
            #1;
            if (req_ready !== 4'b0000) begin
                checks++;
                if (req_ready !== 4'(1 << exp_grant)) begin
                    errors++;
                    $display("FAIL rr_grant got=%b exp_idx=%0d", req_ready, exp_grant);
                end
                exp_q.push_back(model(exp_grant, ops[exp_grant],
                                      8'h11 * 8'(exp_grant + 1), 8'h3C));
                exp_grant = (exp_grant + 1) % NR;
            end
            if (res_valid) begin
                got_res++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rr_unexpected got=%0d/%h", res_id, res_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({res_id, res_data, res_err} !== {e.id, e.data, e.err}) begin
                        errors++;
                        $display("FAIL rr_res got=%0d/%h/%b exp=%0d/%h/%b",
                                 res_id, res_data, res_err, e.id, e.data, e.err);
                    end
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        checks++;
        if (got_res != 6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_count got=%0d pending=%0d exp=6/0", got_res, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        bit   ok;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(model(0, 3'd6, 8'h0F, 8'h30 + 8'(r)));
            issue(0, 3'd6, 8'h0F, 8'h30 + 8'(r));
            wait_res(ok);
            if (ok) begin
                e = exp_q.pop_front();
                checks++;
                if ({res_id, res_data, res_err} !== {e.id, e.data, e.err}) begin
                    errors++;
                    $display("FAIL wrap%0d got=%0d/%h/%b exp=%0d/%h/%b", r,
                             res_id, res_data, res_err, e.id, e.data, e.err);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   ok;
        res_ready = 1'b0;
        exp_q.push_back(model(1, 3'd0, 8'hFF, 8'h0F));
        issue(1, 3'd0, 8'hFF, 8'h0F);
        wait_res(ok);
        set_req(2, 3'd1, 8'h12, 8'h40);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (res_valid !== 1'b1 || res_data !== 8'h0F || res_id !== 2'd1 ||
                res_err !== 1'b0 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold got=%b/%h/%0d/%b/%b exp=1/0f/1/0/0000",
                         res_valid, res_data, res_id, res_err, req_ready);
            end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        checks++;
        if ({res_id, res_data, res_err} !== {e.id, e.data, e.err}) begin
            errors++;
            $display("FAIL bp_res got=%0d/%h/%b exp=%0d/%h/%b",
                     res_id, res_data, res_err, e.id, e.data, e.err);
        end
        res_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_next got=%b/%b exp=0/0100", res_valid, req_ready);
        end
        exp_q.push_back(model(2, 3'd1, 8'h12, 8'h40));
        @(negedge clk);
        req_valid[2] = 1'b0;
        wait_res(ok);
        if (ok) begin
            e = exp_q.pop_front();
            checks++;
            if ({res_id, res_data, res_err} !== {e.id, e.data, e.err}) begin
                errors++;
                $display("FAIL b2b_res got=%0d/%h/%b exp=%0d/%h/%b",
                         res_id, res_data, res_err, e.id, e.data, e.err);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_midop_reset();
        exp_t e;
        bit   ok;
        exp_q.push_back(model(1, 3'd3, 8'h5A, 8'hFF));
        issue(1, 3'd3, 8'h5A, 8'hFF);
        set_req(3, 3'd0, 8'h77, 8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || res_data !== 8'h00 || res_id !== 2'd0 ||
            res_err !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_rst got=%b/%h/%0d/%b/%b exp=0/00/0/0/0000",
                     res_valid, res_data, res_id, res_err, req_ready);
        end
        exp_q.delete();
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_ghost got=%b exp=0", res_valid);
            end
        end
        set_req(1, 3'd0, 8'h5A, 8'hFF);
        set_req(3, 3'd0, 8'h77, 8'h33);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL mid_ptr got=%b exp=0010", req_ready);
        end
        exp_q.push_back(model(1, 3'd0, 8'h5A, 8'hFF));
        @(negedge clk);
        req_valid = '0;
        wait_res(ok);
        if (ok) begin
            e = exp_q.pop_front();
            checks++;
            if ({res_id, res_data, res_err} !== {e.id, e.data, e.err}) begin
                errors++;
                $display("FAIL mid_res got=%0d/%h/%b exp=%0d/%h/%b",
                         res_id, res_data, res_err, e.id, e.data, e.err);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_opcodes();
        test_fairness();
        test_wrap();
        test_back_to_back();
        test_midop_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
